// File: rtl/memory_pkg.sv
// Shared types for the RV32 store path: FSM states, size encoding and the
// AXI-lite OKAY response code.
package memory_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      WAIT_B = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SIZE_NONE = 2'd0,
      SIZE_BYTE = 2'd1,
      SIZE_HALF = 2'd2,
      SIZE_WORD = 2'd3
   } size_t;

   localparam logic [1:0] BRESP_OKAY = 2'b00;

   // Several flags may be set at once; the narrowest size wins.
   function automatic size_t size_decode(input logic is_byte, input logic is_half,
                                         input logic is_word);
      size_t size;
      if (is_byte)      size = SIZE_BYTE;
      else if (is_half) size = SIZE_HALF;
      else if (is_word) size = SIZE_WORD;
      else              size = SIZE_NONE;
      return size;
   endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store-data formatter: replicates the store data across the
// byte lanes, builds the strobe mask and flags misaligned or size-less stores.
module store_align
   import memory_pkg::*;
#(
   parameter int DATA_LEN = 32
) (
   input  logic [1:0]            addr_lo,
   input  logic                  is_byte,
   input  logic                  is_half,
   input  logic                  is_word,
   input  logic [DATA_LEN-1:0]   data,
   output logic [DATA_LEN-1:0]   wdata,
   output logic [DATA_LEN/8-1:0] wstrb,
   output logic                  misalign
);

   always_comb begin
      wdata    = '0;
      wstrb    = '0;
      misalign = 1'b0;
      unique case (size_decode(is_byte, is_half, is_word))
         SIZE_BYTE: begin
            wdata = {4{data[7:0]}};
            wstrb = 4'b0001 << addr_lo;
         end
         SIZE_HALF: begin
            wdata    = {2{data[15:0]}};
            wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
         end
         SIZE_WORD: begin
            wdata    = data;
            wstrb    = 4'b1111;
            misalign = (addr_lo != 2'b00);
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/memory_store_rv32.sv
// RV32 store unit: accepts one LSU store, issues a single AXI-lite AW/W/B
// write, and reports completion with a one-cycle response pulse.
module memory_store_rv32
   import memory_pkg::*;
#(
   parameter int DATA_LEN = 32,
   parameter int ADDR_LEN = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_LEN-1:0]   req_addr,
   input  logic [DATA_LEN-1:0]   req_data,
   input  logic                  is_byte,
   input  logic                  is_half,
   input  logic                  is_word,
   output logic                  resp_valid,
   output logic                  resp_misalign,
   output logic                  resp_err,
   output logic                  mem_awvalid,
   input  logic                  mem_awready,
   output logic [ADDR_LEN-1:0]   mem_awaddr,
   output logic                  mem_wvalid,
   input  logic                  mem_wready,
   output logic [DATA_LEN-1:0]   mem_wdata,
   output logic [DATA_LEN/8-1:0] mem_wstrb,
   input  logic                  mem_bvalid,
   output logic                  mem_bready,
   input  logic [1:0]            mem_bresp
);

   state_t                state_reg, state_next;
   logic [ADDR_LEN-1:0]   awaddr_reg;
   logic [DATA_LEN-1:0]   wdata_reg;
   logic [DATA_LEN/8-1:0] wstrb_reg;
   logic                  aw_done_reg, w_done_reg, misalign_reg, err_reg;

   logic [DATA_LEN-1:0]   align_wdata;
   logic [DATA_LEN/8-1:0] align_wstrb;
   logic                  align_misalign;
   logic                  accept, aw_hs, w_hs, b_hs, send_done;

   store_align #(.DATA_LEN(DATA_LEN)) u_align (
      .addr_lo  (req_addr[1:0]),
      .is_byte  (is_byte),
      .is_half  (is_half),
      .is_word  (is_word),
      .data     (req_data),
      .wdata    (align_wdata),
      .wstrb    (align_wstrb),
      .misalign (align_misalign)
   );

   assign accept    = req_valid && req_ready;
   assign aw_hs     = mem_awvalid && mem_awready;
   assign w_hs      = mem_wvalid && mem_wready;
   assign b_hs      = mem_bvalid && mem_bready;
   // AW and W complete independently; a handshake this cycle counts as done.
   assign send_done = (aw_done_reg || aw_hs) && (w_done_reg || w_hs);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (accept) state_next = align_misalign ? RESP : SEND;
         SEND:    if (send_done) state_next = WAIT_B;
         WAIT_B:  if (b_hs) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready     = (state_reg == IDLE);
      mem_awvalid   = (state_reg == SEND) && !aw_done_reg;
      mem_wvalid    = (state_reg == SEND) && !w_done_reg;
      mem_bready    = (state_reg == WAIT_B);
      resp_valid    = (state_reg == RESP);
      resp_misalign = resp_valid && misalign_reg;
      resp_err      = resp_valid && err_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awaddr_reg   <= '0;
         wdata_reg    <= '0;
         wstrb_reg    <= '0;
         aw_done_reg  <= 1'b0;
         w_done_reg   <= 1'b0;
         misalign_reg <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         if (accept) begin
            awaddr_reg   <= {req_addr[ADDR_LEN-1:2], 2'b00};
            wdata_reg    <= align_wdata;
            wstrb_reg    <= align_wstrb;
            misalign_reg <= align_misalign;
            err_reg      <= 1'b0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
         end
         if (aw_hs) aw_done_reg <= 1'b1;
         if (w_hs)  w_done_reg  <= 1'b1;
         if (b_hs)  err_reg     <= (mem_bresp != BRESP_OKAY);
      end
   end

   assign mem_awaddr = awaddr_reg;
   assign mem_wdata  = wdata_reg;
   assign mem_wstrb  = wstrb_reg;

endmodule

// File: tb/tb_memory_store_rv32.sv
// Bench for memory_store_rv32: scripted stores against a configurable
// AXI-lite slave, with bus writes and responses checked from scoreboards.
module tb_memory_store_rv32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [31:0] req_addr, req_data;
   logic        is_byte, is_half, is_word;
   logic        resp_valid, resp_misalign, resp_err;
   logic        mem_awvalid, mem_awready;
   logic [31:0] mem_awaddr;
   logic        mem_wvalid, mem_wready;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_bvalid, mem_bready;
   logic [1:0]  mem_bresp;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } bus_t;

   typedef struct {
      logic mis;
      logic err;
   } rsp_t;

   bus_t aw_q[$];
   bus_t w_q[$];
   rsp_t rsp_q[$];

   int         checks = 0;
   int         errors = 0;
   int         aw_delay = 0;
   int         w_delay = 0;
   logic [1:0] bresp_cfg = 2'b00;
   bit         b_hold = 1'b0;

   memory_store_rv32 #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .is_byte       (is_byte),
      .is_half       (is_half),
      .is_word       (is_word),
      .resp_valid    (resp_valid),
      .resp_misalign (resp_misalign),
      .resp_err      (resp_err),
      .mem_awvalid   (mem_awvalid),
      .mem_awready   (mem_awready),
      .mem_awaddr    (mem_awaddr),
      .mem_wvalid    (mem_wvalid),
      .mem_wready    (mem_wready),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_bvalid    (mem_bvalid),
      .mem_bready    (mem_bready),
      .mem_bresp     (mem_bresp)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference formatter written from the lane/strobe rules, not the RTL.
   function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                 input logic b, input logic h, input logic w,
                                 output logic [31:0] ed, output logic [3:0] es,
                                 output logic mis);
      ed  = 32'h0;
      es  = 4'h0;
      mis = 1'b0;
      if (b) begin
         ed = {24'h0, d[7:0]} * 32'h0101_0101;
         es = 4'b0001 << a[1:0];
      end else if (h) begin
         ed  = {16'h0, d[15:0]} * 32'h0001_0001;
         es  = a[1] ? 4'hC : 4'h3;
         mis = a[0];
      end else if (w) begin
         ed  = d;
         es  = 4'hF;
         mis = (a[1:0] != 2'b00);
      end else begin
         mis = 1'b1;
      end
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_valids"},
               32'({resp_valid, resp_misalign, resp_err, mem_awvalid, mem_wvalid, mem_bready}), 0);
      check_eq({pfx, "_awaddr"}, mem_awaddr, 0);
      check_eq({pfx, "_wdata"}, mem_wdata, 0);
      check_eq({pfx, "_wstrb"}, 32'(mem_wstrb), 0);
      check_eq({pfx, "_req_ready"}, 32'(req_ready), 1);
   endtask

   function automatic void push_expect(input logic [31:0] a, input logic [31:0] d,
                                       input logic b, input logic h, input logic w,
                                       input logic [1:0] br, input bit want_rsp);
      logic [31:0] ed;
      logic [3:0]  es;
      logic        mis;
      bus_t        e;
      rsp_t        r;
      model(a, d, b, h, w, ed, es, mis);
      if (!mis) begin
         e.addr = {a[31:2], 2'b00};
         e.data = ed;
         e.strb = es;
         aw_q.push_back(e);
         w_q.push_back(e);
      end
      r.mis = mis;
      r.err = !mis && (br != 2'b00);
      if (want_rsp) rsp_q.push_back(r);
   endfunction

   // Called at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                           input logic b, input logic h, input logic w,
                           input int awd, input int wd, input logic [1:0] br,
                           input int exp_lat);
      int n;
      aw_delay  = awd;
      w_delay   = wd;
      bresp_cfg = br;
      push_expect(a, d, b, h, w, br, 1'b1);
      check_eq("req_ready_idle", 32'(req_ready), 1);
      req_addr  = a;
      req_data  = d;
      is_byte   = b;
      is_half   = h;
      is_word   = w;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      while (!resp_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("latency", n, exp_lat);
      $display("store addr=%08h data=%08h bhw=%0b%0b%0b bresp=%0d latency=%0d",
               a, d, b, h, w, br, n);
      @(posedge clk); #1;
   endtask

   // Slave model: per-channel ready delays, B issued after both AW and W.
   initial begin
      int aw_cnt, w_cnt;
      bit got_aw, got_w, b_hs;
      aw_cnt = 0; w_cnt = 0; got_aw = 0; got_w = 0; b_hs = 0;
      mem_awready = 1'b0;
      mem_wready  = 1'b0;
      mem_bvalid  = 1'b0;
      mem_bresp   = 2'b00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            got_aw = 0; got_w = 0; b_hs = 0; aw_cnt = 0; w_cnt = 0;
            mem_bvalid = 1'b0;
         end else begin
            if (mem_awvalid && mem_awready) got_aw = 1;
            if (mem_wvalid && mem_wready)   got_w = 1;
            b_hs = mem_bvalid && mem_bready;
         end
         @(posedge clk); #1;
         if (b_hs) begin
            mem_bvalid = 1'b0;
            b_hs = 0;
         end
         if (got_aw && got_w && !b_hold) begin
            mem_bvalid = 1'b1;
            mem_bresp  = bresp_cfg;
            got_aw = 0;
            got_w  = 0;
         end
         if (mem_awvalid) begin
            if (aw_cnt >= aw_delay) mem_awready = 1'b1;
            else begin mem_awready = 1'b0; aw_cnt++; end
         end else begin
            mem_awready = 1'b0;
            aw_cnt = 0;
         end
         if (mem_wvalid) begin
            if (w_cnt >= w_delay) mem_wready = 1'b1;
            else begin mem_wready = 1'b0; w_cnt++; end
         end else begin
            mem_wready = 1'b0;
            w_cnt = 0;
         end
      end
   end

   // Monitor: bus handshakes and responses popped against the scoreboards.
   initial begin
      logic [31:0] prev_awaddr, prev_wdata;
      logic [3:0]  prev_wstrb;
      bit          aw_pend, w_pend;
      bus_t        e;
      rsp_t        r;
      aw_pend = 0; w_pend = 0;
      prev_awaddr = 0; prev_wdata = 0; prev_wstrb = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (aw_pend) begin
               check_eq("aw_held", 32'(mem_awvalid), 1);
               check_eq("aw_stable", mem_awaddr, prev_awaddr);
            end
            if (w_pend) begin
               check_eq("w_held", 32'(mem_wvalid), 1);
               check_eq("w_stable", {mem_wdata[27:0], mem_wstrb}, {prev_wdata[27:0], prev_wstrb});
            end
            if (mem_awvalid) check_eq("aw_valid_expected", 32'(aw_q.size() != 0), 1);
            if (mem_wvalid)  check_eq("w_valid_expected", 32'(w_q.size() != 0), 1);
            if (mem_awvalid && mem_awready && aw_q.size() != 0) begin
               e = aw_q.pop_front();
               check_eq("awaddr", mem_awaddr, e.addr);
            end
            if (mem_wvalid && mem_wready && w_q.size() != 0) begin
               e = w_q.pop_front();
               check_eq("wdata", mem_wdata, e.data);
               check_eq("wstrb", 32'(mem_wstrb), 32'(e.strb));
            end
            if (resp_valid) begin
               check_eq("resp_expected", 32'(rsp_q.size() != 0), 1);
               if (rsp_q.size() != 0) begin
                  r = rsp_q.pop_front();
                  check_eq("resp_misalign", 32'(resp_misalign), 32'(r.mis));
                  check_eq("resp_err", 32'(resp_err), 32'(r.err));
               end
            end
            aw_pend     = mem_awvalid && !mem_awready;
            w_pend      = mem_wvalid && !mem_wready;
            prev_awaddr = mem_awaddr;
            prev_wdata  = mem_wdata;
            prev_wstrb  = mem_wstrb;
         end else begin
            aw_pend = 0;
            w_pend  = 0;
         end
      end
   end

   initial begin
      logic [8:0] rdy_mask, rsp_mask;
      bit         saw_resp;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      req_data  = 32'h0;
      is_byte   = 1'b0;
      is_half   = 1'b0;
      is_word   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_store(32'h8000_0003, 32'h1234_56AB, 1, 0, 0, 0, 0, 2'b00, 3);
      do_store(32'h8000_0002, 32'hFFFF_BEEF, 0, 1, 0, 0, 0, 2'b00, 3);
      do_store(32'h8000_0001, 32'hFFFF_BEEF, 0, 1, 0, 0, 0, 2'b00, 1);
      do_store(32'h8000_0004, 32'hDEAD_BEEF, 0, 0, 1, 3, 0, 2'b00, 6);
      do_store(32'h8000_0008, 32'h0BAD_F00D, 0, 0, 1, 0, 0, 2'b10, 3);
      do_store(32'h8000_000C, 32'h5555_AAAA, 0, 0, 0, 0, 0, 2'b00, 1);
      do_store(32'h8000_0011, 32'h0000_00C3, 1, 0, 0, 0, 0, 2'b00, 3);
      do_store(32'h8000_0020, 32'h7777_1357, 0, 1, 0, 0, 2, 2'b00, 5);
      do_store(32'h8000_0032, 32'h0102_0304, 0, 0, 1, 0, 0, 2'b00, 1);
      do_store(32'h8000_0043, 32'h89AB_CDEF, 1, 0, 1, 1, 1, 2'b01, 4);

      // Two stores with req_valid held high throughout.
      aw_delay = 0; w_delay = 0; bresp_cfg = 2'b00;
      push_expect(32'h8000_0050, 32'hCAFE_F00D, 0, 0, 1, 2'b00, 1'b1);
      push_expect(32'h8000_0050, 32'hCAFE_F00D, 0, 0, 1, 2'b00, 1'b1);
      req_addr = 32'h8000_0050; req_data = 32'hCAFE_F00D;
      is_byte = 0; is_half = 0; is_word = 1;
      req_valid = 1'b1;
      rdy_mask = '0;
      rsp_mask = '0;
      for (int c = 0; c < 9; c++) begin
         if (c == 5) req_valid = 1'b0;
         rdy_mask[c] = req_ready;
         rsp_mask[c] = resp_valid;
         @(posedge clk); #1;
      end
      check_eq("b2b_ready_cycles", 32'(rdy_mask), 32'h111);
      check_eq("b2b_resp_cycles", 32'(rsp_mask), 32'h088);
      $display("store b2b addr=80000050 ready_mask=%03h resp_mask=%03h", rdy_mask, rsp_mask);

      // Reset while waiting for B: no response must ever appear.
      b_hold = 1'b1;
      push_expect(32'h8000_0060, 32'h1111_2222, 0, 0, 1, 2'b00, 1'b0);
      req_addr = 32'h8000_0060; req_data = 32'h1111_2222;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check_eq("bready_in_wait_b", 32'(mem_bready), 1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      b_hold = 1'b0;
      rst_n  = 1'b1;
      saw_resp = 0;
      repeat (6) begin
         saw_resp = saw_resp | resp_valid;
         @(posedge clk); #1;
      end
      check_eq("no_resp_after_reset", 32'(saw_resp), 0);
      $display("store reset-in-wait_b addr=80000060 resp_seen=%0d", saw_resp);

      do_store(32'h8000_0070, 32'h0000_A55A, 0, 1, 0, 0, 0, 2'b00, 3);
      check_eq("scoreboard_drained", 32'(aw_q.size() + w_q.size() + rsp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
